normalize_shift: RTL and testbench
==================================

NORMALIZE_SHIFT -- requirements
Module: normalize_shift

Interface
REQ-001 The block SHALL have these ports, each as: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input operand present.
- in_ready  out  1  block can accept an operand.
- in_sign  in  1  result sign.
- in_man  in  16  raw mantissa sum. Bit15 is carry; normalized form has bit14 set; bits[1:0] are guard/sticky.
- in_exp  in  6  biased exponent of in_man.
- out_valid  out  1  result present.
- out_ready  in  1  consumer (rounding stage) accepts the result.
- out_sign  out  1  registered sign.
- out_man  out  16  normalized mantissa.
- out_exp  out  6  adjusted exponent.
- out_shift  out  4  number of shift steps performed.
- exception  out  2  00 none, 01 overflow, 10 underflow/subnormal, 11 zero result.

Function
REQ-002 The block SHALL have three states: IDLE, SHIFT and HOLD.
REQ-003 In IDLE: in_ready=1 and out_valid=0. In SHIFT and HOLD: in_ready=0.
REQ-004 On in_valid && in_ready, the block SHALL register sign, man and exp, clear the shift count, and enter SHIFT on the next cycle.
REQ-005 In SHIFT, each cycle SHALL evaluate the registered mantissa and exponent, checking rules REQ-006 to REQ-010 in priority order.
REQ-006 If man==0: set exp=0 and exception=11, then go to HOLD.
REQ-007 If exp>=31: set man=0, exp=31 and exception=01, then go to HOLD.
REQ-008 If man[15]=1:
- shift man right by 1, with new bit0 = old bit1 | old bit0 (sticky preserved);
- exp +1 and shift count +1;
- stay in SHIFT. The next evaluation applies REQ-007.
REQ-009 If man[15]=0 and man[14]=1: exception=00, then go to HOLD.
REQ-010 If man[15:14]=00:
- if exp<=1: exception=10 and go to HOLD with no further shift;
- otherwise shift man left by 1 with 0 shifted in, exp -1, shift count +1, and stay in SHIFT.
REQ-011 In HOLD, out_valid SHALL be 1 and all outputs SHALL be stable. On out_ready=1 the block SHALL return to IDLE on the next cycle; otherwise it stays in HOLD.
REQ-012 Latency from the accept edge to the first out_valid cycle SHALL be 2 + (number of shift steps) cycles. The maximum is 16 cycles (14 left shifts).
REQ-013 The shift count SHALL saturate at 15.
REQ-014 in_valid SHALL be ignored outside IDLE.
REQ-015 Throughput SHALL be at most one operand per (latency + 1) cycles. There is no input buffering.
REQ-016 out_sign SHALL equal the captured sign in every case, including exception cases.

Reset
REQ-017 While rst=1, the block SHALL immediately (asynchronously) go to IDLE with:
- in_ready=1;
- out_valid=0;
- out_man=0, out_exp=0, out_shift=0, exception=00, out_sign=0.
REQ-018 Reset asserted in SHIFT or HOLD SHALL abandon the operand, producing no output.
REQ-019 After rst deasserts, the first rising edge SHALL be able to accept an operand.

Verification
REQ-020 Already normalized: man=0x4003, exp=15 -> out_valid 2 cycles after accept; man=0x4003, exp=15, shift=0, exc=00.
REQ-021 Carry out: man=0x8003, exp=15 -> man=0x4001 (sticky kept), exp=16, shift=1, exc=00, latency 3.
REQ-022 Deep left shift: man=0x0001, exp=20 -> man=0x4000, exp=6, shift=14, exc=00, latency 16.
REQ-023 Boundaries:
- man=0x0100, exp=3 -> man=0x0400, exp=1, exc=10;
- man=0x8000, exp=30 -> man=0, exp=31, exc=01;
- man=0 -> exp=0, exc=11.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable and in_valid ignored; release -> IDLE the next cycle, then a new operand is accepted.
REQ-025 Reset mid-SHIFT: assert rst during a 10-step normalization -> out_valid stays 0 and all outputs are 0 immediately. A subsequent operand is processed correctly.

Source files
------------

// File: rtl/normalize_shift.sv
// Normalizes a raw 16-bit mantissa sum one step per cycle, adjusting the
// exponent and flagging overflow, underflow and zero before rounding.
module normalize_shift (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [15:0] in_man,
    input  logic [5:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [15:0] out_man,
    output logic [5:0]  out_exp,
    output logic [3:0]  out_shift,
    output logic [1:0]  exception
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t      state, state_nx;
    logic        sign_q, sign_nx;
    logic [15:0] man_q, man_nx;
    logic [5:0]  exp_q, exp_nx;
    logic [3:0]  cnt_q, cnt_nx;
    logic [1:0]  exc_q, exc_nx;
    logic [3:0]  cnt_inc;

    assign cnt_inc = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_nx = state;
        sign_nx  = sign_q;
        man_nx   = man_q;
        exp_nx   = exp_q;
        cnt_nx   = cnt_q;
        exc_nx   = exc_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nx  = in_sign;
                    man_nx   = in_man;
                    exp_nx   = in_exp;
                    cnt_nx   = 4'd0;
                    exc_nx   = 2'b00;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (man_q == 16'd0) begin
                    exp_nx   = 6'd0;
                    exc_nx   = 2'b11;
                    state_nx = HOLD;
                end else if (exp_q >= 6'd31) begin
                    man_nx   = 16'd0;
                    exp_nx   = 6'd31;
                    exc_nx   = 2'b01;
                    state_nx = HOLD;
                end else if (man_q[15]) begin
                    // right shift folds the dropped bit into sticky
                    man_nx = {1'b0, man_q[15:2], man_q[1] | man_q[0]};
                    exp_nx = exp_q + 6'd1;
                    cnt_nx = cnt_inc;
                end else if (man_q[14]) begin
                    exc_nx   = 2'b00;
                    state_nx = HOLD;
                end else if (exp_q <= 6'd1) begin
                    exc_nx   = 2'b10;
                    state_nx = HOLD;
                end else begin
                    man_nx = {man_q[14:0], 1'b0};
                    exp_nx = exp_q - 6'd1;
                    cnt_nx = cnt_inc;
                end
            end
            HOLD: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sign_q <= 1'b0;
            man_q  <= 16'd0;
            exp_q  <= 6'd0;
            cnt_q  <= 4'd0;
            exc_q  <= 2'b00;
        end else begin
            state  <= state_nx;
            sign_q <= sign_nx;
            man_q  <= man_nx;
            exp_q  <= exp_nx;
            cnt_q  <= cnt_nx;
            exc_q  <= exc_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_sign  = sign_q;
    assign out_man   = man_q;
    assign out_exp   = exp_q;
    assign out_shift = cnt_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_normalize_shift.sv
// Self-checking bench for normalize_shift: directed corner cases plus
// random operands checked against a leading-one based reference model.
module tb_normalize_shift;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [15:0] in_man = 16'd0;
    logic [5:0]  in_exp = 6'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [15:0] out_man;
    logic [5:0]  out_exp;
    logic [3:0]  out_shift;
    logic [1:0]  exception;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    normalize_shift dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_man    (in_man),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_man   (out_man),
        .out_exp   (out_exp),
        .out_shift (out_shift),
        .exception (exception)
    );

    // Reference: locate the leading one and work out the whole result at once.
    function automatic void model(input logic [15:0] m, input logic [5:0] e,
                                  output logic [15:0] rm, output logic [5:0] re,
                                  output logic [3:0] rs, output logic [1:0] rx);
        int p, need, avail, k;
        rm = 16'd0; re = 6'd0; rs = 4'd0; rx = 2'd0;
        if (m == 16'd0) begin
            rx = 2'b11;
        end else if (e >= 6'd31) begin
            re = 6'd31; rx = 2'b01;
        end else begin
            p = 15;
            while (m[p] == 1'b0) p--;
            if (p == 15) begin
                rm = (m >> 1) | (m & 16'd1);
                re = e + 6'd1;
                rs = 4'd1;
                if (re >= 6'd31) begin
                    rm = 16'd0; re = 6'd31; rx = 2'b01;
                end
            end else begin
                need  = 14 - p;
                avail = (e > 6'd1) ? int'(e) - 1 : 0;
                k     = (need < avail) ? need : avail;
                rm = m << k;
                re = e - 6'(k);
                rs = 4'(k);
                rx = (k < need) ? 2'b10 : 2'b00;
            end
        end
    endfunction

    task automatic start_op(input logic s, input logic [15:0] m, input logic [5:0] e);
        in_sign  = s;
        in_man   = m;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat counts edges from the accept edge through the edge raising out_valid
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic s,
                             input logic [15:0] m, input logic [5:0] e);
        logic [15:0] xm; logic [5:0] xe; logic [3:0] xs; logic [1:0] xx;
        int lat;
        model(m, e, xm, xe, xs, xx);
        start_op(s, m, e);
        wait_valid(lat);
        n_checks++;
        if (out_valid !== 1'b1 || lat !== 2 + int'(xs)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d valid=%b, expected %0d", name, lat, out_valid, 2 + int'(xs));
        end
        n_checks++;
        if ({out_sign, out_man, out_exp, out_shift, exception} !== {s, xm, xe, xs, xx}) begin
            n_fail++;
            $display("FAIL %s result: got s=%b m=%h e=%0d sh=%0d x=%b, expected s=%b m=%h e=%0d sh=%0d x=%b",
                     name, out_sign, out_man, out_exp, out_shift, exception, s, xm, xe, xs, xx);
        end
        release_out();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return_idle: got ready=%b valid=%b, expected 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_sign, out_man, out_exp, out_shift, exception} !== {1'b1, 1'b0, 1'b0, 16'd0, 6'd0, 4'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b valid=%b m=%h e=%0d sh=%0d x=%b, expected 1 0 0 0 0 0",
                     in_ready, out_valid, out_man, out_exp, out_shift, exception);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        run_check("normalized", 1'b0, 16'h4003, 6'd15);
        run_check("carry", 1'b1, 16'h8003, 6'd15);
        run_check("deep_left", 1'b0, 16'h0001, 6'd20);
        run_check("underflow", 1'b1, 16'h0100, 6'd3);
        run_check("overflow", 1'b1, 16'h8000, 6'd30);
        run_check("zero", 1'b1, 16'h0000, 6'd12);
        run_check("exp_big", 1'b0, 16'h4000, 6'd45);
        run_check("exp_zero", 1'b0, 16'h0020, 6'd0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            logic [15:0] m;
            m = 16'($urandom) >> $urandom_range(0, 16);
            run_check("random", 1'($urandom), m, 6'($urandom_range(0, 40)));
        end
    endtask

    task automatic test_backpressure;
        logic [27:0] snap;
        int lat;
        start_op(1'b1, 16'h0400, 6'd10);
        wait_valid(lat);
        snap = {out_sign, out_man, out_exp, out_shift};
        n_checks++;
        if (snap !== {1'b1, 16'h4000, 6'd6, 4'd4} || exception !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_result: got %h x=%b, expected %h x=00", snap, exception, {1'b1, 16'h4000, 6'd6, 4'd4});
        end
        in_valid = 1'b1; in_man = 16'h8000; in_exp = 6'd2; in_sign = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_sign, out_man, out_exp, out_shift} !== snap || exception !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_stable: cycle %0d got valid=%b ready=%b %h, expected 1 0 %h",
                         c, out_valid, in_ready, {out_sign, out_man, out_exp, out_shift}, snap);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%b valid=%b, expected 1 0", in_ready, out_valid);
        end
        run_check("bp_next", 1'b0, 16'h8003, 6'd15);
    endtask

    task automatic test_reset_mid_shift;
        start_op(1'b1, 16'h0010, 6'd20);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_sign, out_man, out_exp, out_shift, exception} !== {1'b1, 1'b0, 1'b0, 16'd0, 6'd0, 4'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL rst_mid: got ready=%b valid=%b s=%b m=%h e=%0d sh=%0d x=%b, expected all zero ready 1",
                     in_ready, out_valid, out_sign, out_man, out_exp, out_shift, exception);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            if (c == 1) begin
                @(negedge clk);
                rst = 1'b0;
            end
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_output: cycle %0d got valid=%b, expected 0", c, out_valid);
            end
        end
        @(negedge clk);
        run_check("after_rst", 1'b0, 16'h0010, 6'd20);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
